// File: rtl/txline_driver.sv
// Serializing line driver: LSB-first shift-out with de-emphasis
// and calibrated source impedance for a transmission-line model.
module txline_driver #(
  parameter int  NBIT    = 8,
  parameter real VHI     = 1.0,
  parameter real VLO     = 0.0,
  parameter real DEEMPH  = 0.0,
  parameter real RS_MIN  = 40.0,
  parameter real RS_STEP = 1.25,
  parameter real RS_OFF  = 1.0e9
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic [NBIT-1:0] din,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [3:0]      rs_code,
  output real             vin,
  output real             rs,
  output logic            busy
);

  localparam int CW = $clog2(NBIT);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t          r_state, w_state;
  logic [NBIT-1:0] r_h, w_h;
  logic            r_hv, w_hv;
  logic [NBIT-1:0] r_s, w_s;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic            r_pb, w_pb;
  logic            r_on, w_on;
  real             r_rs, w_rs;
  real             w_rs_cal;
  logic            w_load;
  logic            w_last;

  assign din_ready = rstn & en & ~r_hv;
  assign busy      = (r_state == SHIFT);
  assign rs        = r_rs;
  assign w_last    = (r_cnt == CW'(NBIT - 1));

  // Line level: full swing on a transition, de-emphasized on a repeat.
  always_comb begin
    vin = VLO;
    if (r_state == SHIFT) begin
      if (r_s[0] != r_pb)
        vin = r_s[0] ? VHI : VLO;
      else if (r_s[0])
        vin = VHI - DEEMPH * (VHI - VLO);
      else
        vin = VLO + DEEMPH * (VHI - VLO);
    end
  end

  // Next-state: handshake, word load, shifting, abort and rs sampling.
  always_comb begin
    w_state  = r_state;
    w_h      = r_h;
    w_hv     = r_hv;
    w_s      = r_s;
    w_cnt    = r_cnt;
    w_pb     = r_pb;
    w_on     = r_on;
    w_rs     = r_rs;
    w_load   = 1'b0;
    w_rs_cal = RS_MIN + RS_STEP * real'(rs_code);
    if (!en) begin
      w_state = IDLE;
      w_hv    = 1'b0;
      w_s     = '0;
      w_cnt   = '0;
      w_pb    = 1'b0;
      w_on    = 1'b0;
      w_rs    = RS_OFF;
    end else begin
      w_on = 1'b1;
      if (!r_on)
        w_rs = w_rs_cal;
      if (din_valid && din_ready) begin
        w_h  = din;
        w_hv = 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (r_hv) begin
            w_s     = r_h;
            w_hv    = 1'b0;
            w_cnt   = '0;
            w_state = SHIFT;
            w_load  = 1'b1;
          end
        end
        SHIFT: begin
          w_pb = r_s[0];
          if (!w_last) begin
            w_s   = r_s >> 1;
            w_cnt = r_cnt + 1'b1;
          end else if (r_hv) begin
            w_s    = r_h;
            w_hv   = 1'b0;
            w_cnt  = '0;
            w_load = 1'b1;
          end else begin
            w_state = IDLE;
            w_s     = '0;
            w_cnt   = '0;
            w_pb    = 1'b0;
          end
        end
      endcase
      if (w_load)
        w_rs = w_rs_cal;
    end
  end

  // State registers with immediate asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_h     <= '0;
      r_hv    <= 1'b0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_pb    <= 1'b0;
      r_on    <= 1'b0;
      r_rs    <= RS_OFF;
    end else begin
      r_state <= w_state;
      r_h     <= w_h;
      r_hv    <= w_hv;
      r_s     <= w_s;
      r_cnt   <= w_cnt;
      r_pb    <= w_pb;
      r_on    <= w_on;
      r_rs    <= w_rs;
    end
  end

endmodule

// File: tb/tb_txline_driver.sv
// Directed bench for txline_driver: vector table plus
// hand-written abort and mid-word reset sequences.
module tb_txline_driver;

  logic       clk;
  logic       rstn;
  logic       en;
  logic [7:0] din;
  logic       din_valid;
  logic [3:0] rs_code;
  logic       rdy0, rdy1;
  logic       busy0, busy1;
  real        vin0, vin1, rs0, rs1;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic       en;
    logic       dv;
    logic [7:0] din;
    logic [3:0] code;
    real        v0;
    real        v1;
    real        rs;
    logic       busy;
    logic       rdy;
  } vec_t;

  vec_t tbl[$];

  txline_driver #(.NBIT(8), .DEEMPH(0.0)) dut0 (
    .clk(clk), .rstn(rstn), .en(en), .din(din),
    .din_valid(din_valid), .din_ready(rdy0),
    .rs_code(rs_code), .vin(vin0), .rs(rs0), .busy(busy0)
  );

  txline_driver #(.NBIT(8), .DEEMPH(0.25)) dut1 (
    .clk(clk), .rstn(rstn), .en(en), .din(din),
    .din_valid(din_valid), .din_ready(rdy1),
    .rs_code(rs_code), .vin(vin1), .rs(rs1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_r(input string nm, input real a, input real e);
    n_tot++;
    if (a - e > 1.0e-6 || e - a > 1.0e-6)
      $display("FAIL %s: got %f want %f", nm, a, e);
    else
      n_pass++;
  endtask

  task automatic chk_b(input string nm, input logic a, input logic e);
    n_tot++;
    if (a !== e)
      $display("FAIL %s: got %b want %b", nm, a, e);
    else
      n_pass++;
  endtask

  task automatic add(input logic e, input logic dv,
                     input logic [7:0] d, input logic [3:0] c,
                     input real v0, input real v1, input real r,
                     input logic b, input logic rd);
    vec_t v;
    v.en = e; v.dv = dv; v.din = d; v.code = c;
    v.v0 = v0; v.v1 = v1; v.rs = r;
    v.busy = b; v.rdy = rd;
    tbl.push_back(v);
  endtask

  task automatic cyc(input logic e, input logic dv, input logic [7:0] d);
    @(negedge clk);
    en = e; din_valid = dv; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; din_valid = 1'b0;
    din = 8'h00; rs_code = 4'd8;

    // 0xA5 from idle, code 8 -> rs 50
    add(1,0,8'h00,8, 0.0,0.0, 50.0, 0,1);
    add(1,1,8'hA5,8, 0.0,0.0, 50.0, 0,0);
    add(1,0,8'h00,8, 1.0,1.0, 50.0, 1,1);
    add(1,0,8'h00,8, 0.0,0.0, 50.0, 1,1);
    add(1,0,8'h00,8, 1.0,1.0, 50.0, 1,1);
    add(1,0,8'h00,8, 0.0,0.0, 50.0, 1,1);
    add(1,0,8'h00,8, 0.0,0.25,50.0, 1,1);
    add(1,0,8'h00,8, 1.0,1.0, 50.0, 1,1);
    add(1,0,8'h00,8, 0.0,0.0, 50.0, 1,1);
    add(1,0,8'h00,8, 1.0,1.0, 50.0, 1,1);
    add(1,0,8'h00,8, 0.0,0.0, 50.0, 0,1);
    // 0xFF then 0x00 back-to-back
    add(1,1,8'hFF,8, 0.0,0.0, 50.0, 0,0);
    add(1,1,8'h00,8, 1.0,1.0, 50.0, 1,1);
    add(1,1,8'h00,8, 1.0,0.75,50.0, 1,0);
    for (int i = 0; i < 6; i++)
      add(1,0,8'h00,8, 1.0,0.75,50.0, 1,0);
    add(1,0,8'h00,8, 0.0,0.0, 50.0, 1,1);
    for (int i = 0; i < 7; i++)
      add(1,0,8'h00,8, 0.0,0.25,50.0, 1,1);
    add(1,0,8'h00,8, 0.0,0.0, 50.0, 0,1);
    // 0x03 at code 0, code -> 15 at bit 3, then 0x01
    add(1,1,8'h03,0, 0.0,0.0, 50.0, 0,0);
    add(1,0,8'h00,0, 1.0,1.0, 40.0, 1,1);
    add(1,0,8'h00,0, 1.0,0.75,40.0, 1,1);
    add(1,0,8'h00,0, 0.0,0.0, 40.0, 1,1);
    add(1,0,8'h00,15,0.0,0.25,40.0, 1,1);
    add(1,0,8'h00,15,0.0,0.25,40.0, 1,1);
    add(1,1,8'h01,15,0.0,0.25,40.0, 1,0);
    add(1,0,8'h00,15,0.0,0.25,40.0, 1,0);
    add(1,0,8'h00,15,0.0,0.25,40.0, 1,0);
    add(1,0,8'h00,15,1.0,1.0, 58.75,1,1);
    add(1,0,8'h00,15,0.0,0.0, 58.75,1,1);
    for (int i = 0; i < 6; i++)
      add(1,0,8'h00,15,0.0,0.25,58.75,1,1);
    add(1,0,8'h00,15,0.0,0.0, 58.75,0,1);

    // reset state, en already high
    #12;
    chk_r("rst vin", vin0, 0.0);
    chk_r("rst rs", rs0, 1.0e9);
    chk_b("rst busy", busy0, 1'b0);
    chk_b("rst ready", rdy0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk_r("rel rs hold", rs0, 1.0e9);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      en = tbl[i].en; din_valid = tbl[i].dv;
      din = tbl[i].din; rs_code = tbl[i].code;
      @(posedge clk);
      #1;
      chk_r($sformatf("row%0d vin0", i), vin0, tbl[i].v0);
      chk_r($sformatf("row%0d vin1", i), vin1, tbl[i].v1);
      chk_r($sformatf("row%0d rs", i), rs0, tbl[i].rs);
      chk_b($sformatf("row%0d busy", i), busy0, tbl[i].busy);
      chk_b($sformatf("row%0d ready", i), rdy0, tbl[i].rdy);
    end

    // abort at bit 4 of 0x5A with H holding 0x3C
    rs_code = 4'd8;
    cyc(1, 1, 8'h5A);
    cyc(1, 0, 8'h00);
    cyc(1, 1, 8'h3C);
    chk_b("ab hfull", rdy0, 1'b0);
    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h00);
    chk_r("ab bit4", vin0, 1.0);
    chk_b("ab busy pre", busy0, 1'b1);
    cyc(0, 0, 8'h00);
    chk_r("ab vin", vin0, 0.0);
    chk_r("ab rs", rs0, 1.0e9);
    chk_b("ab busy", busy0, 1'b0);
    chk_b("ab ready", rdy0, 1'b0);
    cyc(1, 0, 8'h00);
    chk_r("ren rs", rs0, 50.0);
    chk_b("ren ready", rdy0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 8'h00);
      chk_b($sformatf("ren busy%0d", i), busy0, 1'b0);
      chk_r($sformatf("ren vin%0d", i), vin0, 0.0);
    end

    // reset mid-word between edges with H full
    cyc(1, 1, 8'hC3);
    cyc(1, 1, 8'h81);
    chk_r("mr bit0", vin0, 1.0);
    cyc(1, 1, 8'h81);
    chk_b("mr hfull", rdy0, 1'b0);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk_r("mr vin", vin0, 0.0);
    chk_r("mr rs", rs0, 1.0e9);
    chk_b("mr busy", busy0, 1'b0);
    chk_b("mr ready", rdy0, 1'b0);
    rstn = 1'b1;
    din_valid = 1'b0;
    #1;
    chk_r("mr rs hold", rs0, 1.0e9);
    @(posedge clk);
    #1;
    chk_r("mr rs edge", rs0, 50.0);
    chk_b("mr busy edge", busy0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 8'h00);
      chk_b($sformatf("mr busy%0d", i), busy0, 1'b0);
      chk_r($sformatf("mr vin%0d", i), vin0, 0.0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
